// File: rtl/uart_mem_dumper_pkg.sv
// Shared definitions for the SRAM-to-UART word dumper: UART frame layout,
// dumper FSM encoding and the baud divisor helper.
package uart_mem_dumper_pkg;

  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;
  localparam int   DATA_BITS      = 8;
  localparam int   FRAME_BITS     = DATA_BITS + 2;
  localparam int   BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_SEND,
    ST_FINISH
  } dump_state_e;

  function automatic int calc_clks_per_bit(input int sys_clk_freq, input int baud);
    return sys_clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_mem_dumper_tx_byte.sv
// UART 8N1 byte serializer. Ready is high while idle and also during the last
// clock of the stop bit, so a byte offered then starts its start bit with no gap.
module uart_tx_byte
  import uart_mem_dumper_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 valid,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(FRAME_BITS - 1);

  logic                 active;
  logic [CNT_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS:0]   frame;
  logic                 bit_end;

  assign bit_end = (baud_cnt == LAST_TICK);
  assign ready   = !active || (bit_end && (bit_idx == LAST_BIT));

  // Load a new frame on handshake, otherwise step through bits at the baud rate.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      frame    <= '1;
      tx       <= STOP_BIT;
    end else if (valid && ready) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      frame    <= {STOP_BIT, data};
      tx       <= START_BIT;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_idx == LAST_BIT) begin
          active <= 1'b0;
        end else begin
          bit_idx <= bit_idx + 1'b1;
          tx      <= frame[0];
          frame   <= {STOP_BIT, frame[DATA_BITS:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_mem_dumper.sv
// Reads a block of 32-bit SRAM words and streams them out over UART,
// least significant byte first. Owns the SRAM port while busy_o is high.
module uart_mem_dumper
  import uart_mem_dumper_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 60000000,
  parameter int BAUD         = 9600,
  parameter int ADDR_WIDTH   = 13
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   word_count_i,
  output logic                  mem_csb_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [31:0]           mem_data_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(SYS_CLK_FREQ, BAUD);

  dump_state_e          state;
  logic [ADDR_WIDTH:0]  remaining;
  logic [1:0]           byte_left;
  logic [31:0]          word_reg;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] tx_data;

  // Byte 0 goes straight from the SRAM bus during WAIT so the start bit begins
  // without an extra cycle; later bytes come from the shifted word register.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = word_reg[DATA_BITS-1:0];
    if (state == ST_WAIT) begin
      tx_valid = 1'b1;
      tx_data  = mem_data_i[DATA_BITS-1:0];
    end else if (state == ST_SEND && byte_left != 2'd0) begin
      tx_valid = 1'b1;
    end
  end

  // Dump sequencer: fetch a word, serialize its four bytes, advance address.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= ST_IDLE;
      mem_csb_o  <= 1'b1;
      mem_addr_o <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      remaining  <= '0;
      byte_left  <= 2'd0;
      word_reg   <= '0;
    end else begin
      done_o    <= 1'b0;
      mem_csb_o <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            busy_o     <= 1'b1;
            remaining  <= word_count_i;
            mem_addr_o <= base_addr_i;
            if (word_count_i == '0) begin
              state <= ST_FINISH;
            end else begin
              state     <= ST_READ;
              mem_csb_o <= 1'b0;
            end
          end
        end
        ST_READ: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          word_reg  <= {8'h00, mem_data_i[31:8]};
          byte_left <= 2'(BYTES_PER_WORD - 1);
          state     <= ST_SEND;
        end
        ST_SEND: begin
          if (tx_valid && tx_ready) begin
            word_reg  <= {8'h00, word_reg[31:8]};
            byte_left <= byte_left - 2'd1;
          end else if (byte_left == 2'd0 && tx_ready) begin
            mem_addr_o <= mem_addr_o + 1'b1;
            remaining  <= remaining - 1'b1;
            if (remaining == (ADDR_WIDTH+1)'(1)) begin
              state <= ST_FINISH;
            end else begin
              state     <= ST_READ;
              mem_csb_o <= 1'b0;
            end
          end
        end
        ST_FINISH: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .valid  (tx_valid),
    .data   (tx_data),
    .ready  (tx_ready),
    .tx     (tx_o)
  );

endmodule

// File: tb/tb_uart_mem_dumper.sv
// Directed bench for uart_mem_dumper at 16 clocks per bit: SRAM model,
// UART decoder, table of dump vectors plus mid-dump start and reset cases.
module tb_uart_mem_dumper;

  localparam int AW  = 13;
  localparam int BIT = 16;

  typedef struct packed {
    logic [AW-1:0]       base;
    logic [AW:0]         count;
    int                  nwords;
    logic [1:0][AW-1:0]  addr;
    logic [1:0][31:0]    word;
    int                  nbytes;
    logic [7:0][7:0]     bytes;
    int                  done_off;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic          mem_csb;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic          tx;
  logic          busy;
  logic          done;

  logic [31:0]   mem [0:(1<<AW)-1];
  vec_t          vecs [4];

  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            done_cnt = 0;
  int            frame_err = 0;
  logic [7:0]    dec_q [$];
  int            fs_q [$];
  int            rd_q [$];
  logic          dec_active = 1'b0;
  int            dec_cnt = 0;
  logic [7:0]    dec_byte = 8'h00;

  uart_mem_dumper #(
    .SYS_CLK_FREQ(160),
    .BAUD        (10),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk_i       (clk),
    .reset_i     (rst),
    .start_i     (start),
    .base_addr_i (base_addr),
    .word_count_i(word_count),
    .mem_csb_o   (mem_csb),
    .mem_addr_o  (mem_addr),
    .mem_data_i  (mem_rdata),
    .tx_o        (tx),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  // Clock-edge counter used as the timebase for all latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: read data valid the cycle after chip select is low.
  always @(posedge clk) begin
    if (!mem_csb) mem_rdata <= mem[mem_addr];
  end

  // Log every SRAM access address and every done pulse.
  always @(negedge clk) begin
    if (mem_csb === 1'b0) rd_q.push_back(int'(mem_addr));
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // UART receiver sampling mid-bit; abandons a frame when the dumper goes idle.
  always @(negedge clk) begin
    if (busy !== 1'b1) begin
      dec_active <= 1'b0;
    end else if (!dec_active) begin
      if (tx === 1'b0) begin
        dec_active <= 1'b1;
        dec_cnt    <= 1;
        fs_q.push_back(cyc);
      end
    end else begin
      dec_cnt <= dec_cnt + 1;
      if (dec_cnt % BIT == BIT/2) begin
        if (dec_cnt / BIT == 0) begin
          if (tx !== 1'b0) frame_err <= frame_err + 1;
        end else if (dec_cnt / BIT <= 8) begin
          dec_byte <= {tx, dec_byte[7:1]};
        end else begin
          if (tx !== 1'b1) frame_err <= frame_err + 1;
          else dec_q.push_back(dec_byte);
          dec_active <= 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual,
               expected, expected);
    end
  endtask

  function automatic int byteAt(input int idx);
    if (idx < dec_q.size()) return int'(dec_q[idx]);
    return -1;
  endfunction

  function automatic int readAt(input int idx);
    if (idx < rd_q.size()) return rd_q[idx];
    return -1;
  endfunction

  function automatic int startAt(input int idx);
    if (idx < fs_q.size()) return fs_q[idx];
    return -1;
  endfunction

  task automatic applyStimulus(input logic [AW-1:0] base, input logic [AW:0] count,
                               input int glitch_off, output int t0, output int done_off);
    @(negedge clk);
    base_addr  = base;
    word_count = count;
    start      = 1'b1;
    t0         = cyc + 1;
    @(negedge clk);
    start      = 1'b0;
    base_addr  = AW'($urandom);
    word_count = (AW+1)'($urandom);
    checkOutput("busy_after_start", int'(busy), 1);
    done_off = -1;
    for (int k = 0; k < 5000; k++) begin
      if (done === 1'b1) begin
        done_off = cyc - t0;
        break;
      end
      start = (glitch_off > 0 && (cyc - t0) == glitch_off) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic runVector(input int i, input int glitch_off);
    int b0 = dec_q.size();
    int f0 = fs_q.size();
    int r0 = rd_q.size();
    int e0 = frame_err;
    int t0;
    int done_off;
    applyStimulus(vecs[i].base, vecs[i].count, glitch_off, t0, done_off);
    checkOutput($sformatf("v%0d_done_cycle", i), done_off, vecs[i].done_off);
    @(negedge clk);
    checkOutput($sformatf("v%0d_done_width", i), int'(done), 0);
    checkOutput($sformatf("v%0d_busy_end", i), int'(busy), 0);
    checkOutput($sformatf("v%0d_nbytes", i), dec_q.size() - b0, vecs[i].nbytes);
    for (int j = 0; j < vecs[i].nbytes; j++)
      checkOutput($sformatf("v%0d_byte%0d", i, j), byteAt(b0 + j), int'(vecs[i].bytes[j]));
    checkOutput($sformatf("v%0d_nreads", i), rd_q.size() - r0, vecs[i].nwords);
    for (int j = 0; j < vecs[i].nwords; j++)
      checkOutput($sformatf("v%0d_addr%0d", i, j), readAt(r0 + j), int'(vecs[i].addr[j]));
    checkOutput($sformatf("v%0d_frame_err", i), frame_err - e0, 0);
    if (vecs[i].nbytes == 0)
      checkOutput($sformatf("v%0d_no_start", i), fs_q.size() - f0, 0);
    else
      checkOutput($sformatf("v%0d_first_start", i), startAt(f0) - t0, 2);
    if (vecs[i].nwords == 2)
      checkOutput($sformatf("v%0d_word2_start", i), startAt(f0 + 4) - t0, 40*BIT + 2 + 2);
  endtask

  initial begin
    int t0;
    int b0;
    int d0;
    int r0;

    vecs[0] = '{base: 13'd5, count: 14'd1, nwords: 1,
                addr: {13'd0, 13'd5}, word: {32'h0, 32'hA1B2C3D4},
                nbytes: 4, bytes: {32'h0, 8'hA1, 8'hB2, 8'hC3, 8'hD4}, done_off: 643};
    vecs[1] = '{base: 13'd0, count: 14'd0, nwords: 0,
                addr: '0, word: '0, nbytes: 0, bytes: '0, done_off: 1};
    vecs[2] = '{base: 13'd8191, count: 14'd2, nwords: 2,
                addr: {13'd0, 13'd8191}, word: {32'hCAFEF00D, 32'h11223344},
                nbytes: 8, bytes: {8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h11, 8'h22, 8'h33, 8'h44},
                done_off: 1285};
    vecs[3] = '{base: 13'd100, count: 14'd1, nwords: 1,
                addr: {13'd0, 13'd100}, word: {32'h0, 32'h00FF55AA},
                nbytes: 4, bytes: {32'h0, 8'h00, 8'hFF, 8'h55, 8'hAA}, done_off: 643};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < vecs[i].nwords; j++) mem[vecs[i].addr[j]] = vecs[i].word[j];

    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_tx", int'(tx), 1);
    checkOutput("reset_csb", int'(mem_csb), 1);
    checkOutput("reset_addr", int'(mem_addr), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) runVector(i, 0);

    runVector(0, 100);

    b0 = dec_q.size();
    d0 = done_cnt;
    r0 = rd_q.size();
    @(negedge clk);
    base_addr  = 13'd5;
    word_count = 14'd1;
    start      = 1'b1;
    t0         = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc - t0 < 2 + 10*BIT + 40) @(negedge clk);
    checkOutput("abort_busy_before", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_tx", int'(tx), 1);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_csb", int'(mem_csb), 1);
    repeat (700) @(negedge clk);
    checkOutput("abort_no_done", done_cnt - d0, 0);
    checkOutput("abort_tx_idle", int'(tx), 1);
    checkOutput("abort_nreads", rd_q.size() - r0, 1);
    checkOutput("abort_nbytes", dec_q.size() - b0, 1);
    checkOutput("abort_byte0", byteAt(b0), 8'hD4);

    runVector(3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
